add_sequencer: RTL
==================

// Module: add_sequencer
// PURPOSE
//  Drives the shared 4-bit carry-lookahead adder to perform WIDTH-bit add/subtract, one nibble per pass.
//  Latches operands on a start pulse and walks nibbles LSB->MSB, chaining carry between passes.
//  Returns result, flags and a one-cycle done pulse to the CPU datapath.
//  Sits between the ALU control FSM and the adder; sole owner of the adder's en/ready handshake.
// PARAMETERS
//  WIDTH          8   operand/result width; must be a multiple of 4 (N = WIDTH/4 nibbles)
//  READY_TIMEOUT  15  max add_en-high cycles waiting for add_ready before error abort
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      request; sampled only in IDLE
//  sub        in   1      0 = a+b, 1 = a-b (two's complement); latched with start
//  a, b       in   WIDTH  operands; latched with start
//  busy       out  1      high from cycle after accepted start until DONE cycle inclusive
//  done       out  1      one-cycle pulse, result/flags valid from this cycle
//  err        out  1      valid with done: adder failed to respond (timeout)
//  result     out  WIDTH  sum/difference, held until next accepted start
//  carry      out  1      final nibble carry-out (sub: 1 = no borrow)
//  overflow   out  1      signed overflow
//  zero       out  1      result == 0
//  add_en     out  1      adder enable; held high for a whole pass
//  add_a/add_b out 4      current nibble operands (add_b already inverted for sub)
//  add_cin    out  1      carry into current nibble
//  add_sum    in   4      adder sum
//  add_cout   in   1      adder carry-out
//  add_ready  in   1      adder result valid
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err, carry, overflow, zero, add_en, add_cin = 0; result, add_a, add_b = 0.
//  States: IDLE, RUN, CAPTURE, DONE.
//  IDLE: start=1 -> latch a, b^{WIDTH{sub}}, sub; nib_idx=0; cin=sub; -> RUN. start while not IDLE is ignored.
//  RUN: add_en=1; add_a/add_b = nibble nib_idx; add_cin = chained carry; wait counter increments.
//   add_ready=1 sampled -> CAPTURE. Counter reaching READY_TIMEOUT first -> err=1, result=0, flags=0 -> DONE.
//  CAPTURE: add_en=0 for exactly 1 cycle (this clears the adder's internal count before the next pass).
//   Store add_sum into result[4*nib_idx+:4]; chained carry <= add_cout; wait counter cleared.
//   nib_idx<N-1 -> nib_idx+1, RUN; else carry=add_cout, overflow=(a_msb==b'_msb)&&(sum_msb!=a_msb), zero -> DONE.
//  DONE: done=1, busy=1 for this one cycle -> IDLE. Flags/result stable until next accepted start.
//  add_en never high in IDLE, CAPTURE, DONE; add_en is never high on two passes without an intervening low cycle.
//  Latency (start edge to done) = sum over N passes of (Rk+1) + 1 cycles, Rk = RUN cycles of pass k.
//  Operand/sub changes after acceptance have no effect. Result nibbles not yet written read as previous value
//   only internally; result output updates only at DONE (shadow register).
//  Reset mid-operation: immediate return to IDLE, add_en=0 the following cycle, no done pulse.
// TESTING (bench uses behavioural adder model, ready after 3 en-high edges unless stated)
//  8'h3C + 8'h45, sub=0 -> result 8'h81, carry 0, overflow 1, zero 0, err 0; done exactly 1 cycle.
//  8'hFF + 8'h01 -> result 8'h00, carry 1, zero 1, overflow 0; nibble carry chained into pass 2.
//  8'h10 - 8'h20, sub=1 -> result 8'hF0, carry 0 (borrow), overflow 0; first add_cin=1, add_b=4'hF.
//  Model never raises ready -> err=1 after 15 RUN cycles, result 0, done pulse, back to IDLE.
//  start re-pulsed while busy, and rst_n low during pass 2 -> second start ignored; reset gives IDLE, no done.
//  Check add_en low for exactly 1 cycle between passes; latency 9 cycles for WIDTH=8 with 3-cycle adder.

Source files
------------

// File: rtl/add_sequencer.sv
// add_sequencer
//   Performs a WIDTH-bit add or subtract on a shared 4-bit adder, one nibble
//   per pass from LSB to MSB, with the carry chained between passes.
//   Operands are latched on an accepted start. Result and flags are delivered
//   with a one-cycle done pulse.
//
// Ports
//   clk, rst_n          clock and synchronous active-low reset
//   start, sub, a, b    request, operation select (1 = a-b) and operands
//   busy, done, err     status: busy while working, done pulse, timeout error
//   result, carry,
//   overflow, zero      outcome, held until the next op completes
//   add_en, add_a,
//   add_b, add_cin      drive to the shared nibble adder
//   add_sum, add_cout,
//   add_ready           response from the shared nibble adder
//   dbg_state           current FSM state (0 IDLE, 1 RUN, 2 CAPTURE, 3 DONE)
//
// Adder handshake: add_en is held high for an entire pass. The adder signals
// completion by raising add_ready. The sum is taken on the first clock edge
// at which add_en and add_ready are both high. add_en then drops for exactly
// one cycle, CAPTURE, so the adder can clear its internal state before the
// next pass.
module add_sequencer #(
  parameter int WIDTH         = 8,
  parameter int READY_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             add_en,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  input  logic             add_ready,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / 4;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(READY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;     // already inverted for subtract
  logic [WIDTH-1:0] work;    // shadow result, filled nibble by nibble
  logic             chain;   // carry into the current nibble
  logic [NW-1:0]    nib_idx;
  logic [CW-1:0]    wait_cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             last_nib;
  logic             timeout_hit;

  assign last_nib    = (nib_idx == NW'(N - 1));
  assign timeout_hit = (wait_cnt == CW'(READY_TIMEOUT - 1));
  assign a_sh        = a_q >> {nib_idx, 2'b00};
  assign b_sh        = b_q >> {nib_idx, 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RUN;
      S_RUN: begin
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (add_ready)        state_nxt = S_CAPTURE;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_CAPTURE: state_nxt = last_nib ? S_DONE : S_RUN;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    add_en    = (state == S_RUN);
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    dbg_state = state;
    if (state == S_RUN) begin
      add_a   = a_sh[3:0];
      add_b   = b_sh[3:0];
      add_cin = chain;
    end
  end

  // Datapath. The nibble sum is taken on the edge where ready is seen. That
  // way the value does not depend on the adder holding its outputs once
  // add_en drops. CAPTURE then advances the pass or publishes the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      work     <= '0;
      chain    <= 1'b0;
      nib_idx  <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b ^ {WIDTH{sub}};
            chain    <= sub;
            nib_idx  <= '0;
            wait_cnt <= '0;
          end
        end
        S_RUN: begin
          if (add_ready) begin
            work[{nib_idx, 2'b00} +: 4] <= add_sum;
            chain    <= add_cout;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            err      <= 1'b1;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          wait_cnt <= '0;
          if (last_nib) begin
            err      <= 1'b0;
            result   <= work;
            carry    <= chain;
            // Signed overflow: operands as seen by the adder share a sign,
            // and the sum has the other sign.
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (work[WIDTH-1] != a_q[WIDTH-1]);
            zero     <= (work == '0);
          end else begin
            nib_idx <= nib_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
